// File: rtl/arb_requester.sv
// Burst requester for one round-robin arbiter port: takes a local job, requests the
// shared bus, streams job_data+i beats while granted, and gives up after TIMEOUT cycles.
module arb_requester #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       job_valid_i,
    input  logic [3:0] job_len_i,
    input  logic [7:0] job_data_i,
    output logic       job_ready_o,
    output logic       request_o,
    input  logic       grant_i,
    output logic       bus_valid_o,
    output logic [7:0] bus_data_o,
    output logic       bus_last_o,
    output logic       busy_o,
    output logic       timeout_err_o,
    output logic [1:0] state_o
);

    // Handshake: a job is taken at a rising edge where job_valid_i=1 and job_ready_o=1;
    // a beat moves at a rising edge where bus_valid_o=1 (i.e. XFER and grant_i=1).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [7:0] data_q, data_d;
    logic [3:0] beat_q, beat_d;
    logic [7:0] wait_q, wait_d;
    logic       request_q, request_d;
    logic       timeout_err_q, timeout_err_d;
    logic       beat_is_last;

    assign beat_is_last = (beat_q == len_q - 4'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            len_q         <= 4'd0;
            data_q        <= 8'd0;
            beat_q        <= 4'd0;
            wait_q        <= 8'd0;
            request_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            data_q        <= data_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            request_q     <= request_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        data_d        = data_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    state_d = S_REQ;
                    len_d   = (job_len_i == 4'd0) ? 4'd1 : job_len_i;
                    data_d  = job_data_i;
                    beat_d  = 4'd0;
                    wait_d  = 8'd0;
                end
            end
            S_REQ: begin
                // A grant on the final wait cycle still wins over the timeout.
                if (grant_i) begin
                    state_d = S_XFER;
                end else if (wait_q == WAIT_LAST) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_XFER: begin
                if (grant_i) begin
                    if (beat_is_last) begin
                        state_d = S_REL;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        request_d = (state_d == S_REQ) || (state_d == S_XFER);
    end

    always_comb begin
        job_ready_o   = (state_q == S_IDLE);
        busy_o        = (state_q != S_IDLE);
        bus_valid_o   = (state_q == S_XFER) && grant_i;
        bus_data_o    = bus_valid_o ? (data_q + {4'd0, beat_q}) : 8'd0;
        bus_last_o    = bus_valid_o && beat_is_last;
        request_o     = request_q;
        timeout_err_o = timeout_err_q;
        state_o       = state_q;
    end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: job-level reference model compared every cycle, directed
// burst/timeout/reset scenarios with literal beat lists, then randomized traffic.
module tb_arb_requester;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       job_valid = 1'b0;
    logic [3:0] job_len = 4'd0;
    logic [7:0] job_data = 8'd0;
    logic       grant = 1'b0;
    logic       job_ready, request, bus_valid, bus_last, busy, timeout_err;
    logic [7:0] bus_data;
    logic [1:0] state_dbg;

    arb_requester #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .job_valid_i(job_valid), .job_len_i(job_len),
        .job_data_i(job_data), .job_ready_o(job_ready), .request_o(request),
        .grant_i(grant), .bus_valid_o(bus_valid), .bus_data_o(bus_data),
        .bus_last_o(bus_last), .busy_o(busy), .timeout_err_o(timeout_err),
        .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a held job is either waiting for grant or mid-burst with
    // some beats already moved; a released job leaves one dead cycle.
    bit m_held = 0, m_granted = 0, m_rel = 0, m_to = 0;
    int m_waited = 0, m_done = 0, m_len = 0, m_base = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held = 0; m_granted = 0; m_rel = 0; m_to = 0;
            m_waited = 0; m_done = 0;
        end else begin
            m_to = 0;
            if (m_rel) begin
                m_rel = 0;
            end else if (!m_held) begin
                if (job_valid) begin
                    m_held = 1; m_granted = 0; m_waited = 0; m_done = 0;
                    m_len = (job_len == 0) ? 1 : int'(job_len);
                    m_base = int'(job_data);
                end
            end else if (!m_granted) begin
                if (grant) m_granted = 1;
                else if (m_waited + 1 == TIMEOUT) begin m_held = 0; m_to = 1; end
                else m_waited++;
            end else if (grant) begin
                m_done++;
                if (m_done == m_len) begin m_held = 0; m_rel = 1; end
            end
        end
    end

    // Observation log for directed scenarios: {last, data} per beat.
    logic [8:0] obs_q[$];
    int req_hi = 0, to_cnt = 0, gap = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_valid;
            e_valid = m_held && m_granted && grant;
            check("job_ready", job_ready, !m_held && !m_rel);
            check("request", request, m_held);
            check("busy", busy, m_held || m_rel);
            check("bus_valid", bus_valid, e_valid);
            check("bus_data", bus_data, e_valid ? (m_base + m_done) % 256 : 0);
            check("bus_last", bus_last, e_valid && (m_len - m_done == 1));
            check("timeout_err", timeout_err, m_to);
        end
        if (bus_valid) obs_q.push_back({bus_last, bus_data});
        if (request) req_hi++;
        if (timeout_err) to_cnt++;
        if (request && !bus_valid && obs_q.size() > 0) gap++;
    end

    task automatic clear_log();
        obs_q.delete();
        req_hi = 0; to_cnt = 0; gap = 0;
    endtask

    task automatic send_job(input logic [3:0] len, input logic [7:0] data);
        @(posedge clk); #1;
        job_valid = 1'b1; job_len = len; job_data = data;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!job_ready && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) check("idle_wait_expired", 0, 1);
    endtask

    task automatic wait_beats(input int nb, input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (obs_q.size() < nb && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() < nb) check("beat_wait_expired", obs_q.size(), nb);
    endtask

    task automatic check_beats(input string name, input logic [8:0] exp_q[$]);
        check({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(name, obs_q[i], exp_q[i]);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", job_ready, 1);
        check("reset_request", request, 0);
        rst_n = 1'b1;

        // Three-beat burst, grant one cycle after request rises.
        clear_log();
        send_job(4'd3, 8'h10);
        @(posedge clk); #1 grant = 1'b1;
        wait_idle(40);
        grant = 1'b0;
        check_beats("burst3", '{9'h010, 9'h011, 9'h112});

        // Zero length means one beat; grant already present.
        clear_log();
        grant = 1'b1;
        send_job(4'd0, 8'hFF);
        wait_idle(40);
        check_beats("len0", '{9'h1FF});

        // Data wraps modulo 256.
        clear_log();
        send_job(4'd4, 8'hFE);
        wait_idle(40);
        check_beats("wrap", '{9'h0FE, 9'h0FF, 9'h000, 9'h101});

        // Grant withdrawn for two cycles after the second beat.
        clear_log();
        send_job(4'd4, 8'h20);
        wait_beats(2, 40);
        @(posedge clk); #1 grant = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 grant = 1'b1;
        wait_idle(40);
        check_beats("pause", '{9'h020, 9'h021, 9'h022, 9'h123});
        check("pause_gap", gap, 2);

        // Grant never arrives: request for TIMEOUT cycles then a single error pulse.
        clear_log();
        grant = 1'b0;
        send_job(4'd2, 8'h33);
        wait_idle(60);
        repeat (3) @(posedge clk);
        check("timeout_req_cycles", req_hi, TIMEOUT);
        check("timeout_pulses", to_cnt, 1);
        check("timeout_beats", obs_q.size(), 0);

        // Grant on the last wait cycle beats the timeout.
        clear_log();
        send_job(4'd2, 8'h70);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 grant = 1'b1;
        wait_idle(60);
        check("late_grant_pulses", to_cnt, 0);
        check_beats("late_grant", '{9'h070, 9'h171});

        // Reset during the second of five beats, then a fresh full burst.
        clear_log();
        send_job(4'd5, 8'h40);
        wait_beats(2, 40);
        #1 rst_n = 1'b0;
        #1;
        check("rst_request", request, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_bus_data", bus_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
        send_job(4'd5, 8'h50);
        wait_idle(40);
        check_beats("after_rst", '{9'h050, 9'h051, 9'h052, 9'h053, 9'h154});

        // Randomized traffic with varying grant density and rare resets.
        for (int seg = 0; seg < 40; seg++) begin
            int gp;
            gp = $urandom_range(0, 4);
            for (int c = 0; c < 80; c++) begin
                @(posedge clk); #1;
                rst_n = ($urandom_range(0, 299) != 0);
                job_valid = $urandom_range(0, 1);
                job_len = 4'($urandom);
                job_data = 8'($urandom);
                grant = (gp == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, gp) != 0);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; job_valid = 1'b0; grant = 1'b1;
        wait_idle(60);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
